// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (MULDIV_FAST_MUL_EN selects a single-cycle multiplier)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       alucode,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out
);
    localparam logic [5:0] ALU_MUL    = 6'd20;
    localparam logic [5:0] ALU_MULH   = 6'd21;
    localparam logic [5:0] ALU_MULHSU = 6'd22;
    localparam logic [5:0] ALU_MULHU  = 6'd23;
    localparam logic [5:0] ALU_DIV    = 6'd24;
    localparam logic [5:0] ALU_DIVU   = 6'd25;
    localparam logic [5:0] ALU_REM    = 6'd26;
    localparam logic [5:0] ALU_REMU   = 6'd27;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt, op;
    logic [4:0]  rd_q;
    logic        neg;
    logic [63:0] a, acc, acc_nxt, prod;
    logic [31:0] b, m1, m2, rem_nxt, quo_nxt, mul_res, div_res, special_res, fast_res;
    logic [32:0] trial;
    logic        is_m, is_mul_in, rem_in, n1, n2, neg_in, div0, ovf, special, accept, direct_mul, ge;

    assign is_m        = alucode inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    assign is_mul_in   = alucode inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    assign rem_in      = alucode inside {ALU_REM, ALU_REMU};
    assign n1          = (alucode inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) & src1[31];
    assign n2          = (alucode inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM}) & src2[31];
    assign m1          = n1 ? -src1 : src1;
    assign m2          = n2 ? -src2 : src2;
    assign neg_in      = rem_in ? n1 : n1 ^ n2;
    assign div0        = !is_mul_in && src2 == 32'd0;
    assign ovf         = (alucode inside {ALU_DIV, ALU_REM}) && src1 == 32'h8000_0000 && src2 == 32'hFFFF_FFFF;
    assign special     = div0 || ovf;
    assign special_res = div0 ? (rem_in ? src1 : 32'hFFFF_FFFF) : (rem_in ? 32'd0 : 32'h8000_0000);
    assign accept      = state == IDLE && start && is_m && !flush;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod, fast_signed;
    assign fast_prod   = {32'd0, m1} * {32'd0, m2};
    assign fast_signed = neg_in ? -fast_prod : fast_prod;
    assign fast_res    = alucode == ALU_MUL ? fast_signed[31:0] : fast_signed[63:32];
    assign direct_mul  = 1'b1;
`else
    assign fast_res    = 32'd0;
    assign direct_mul  = 1'b0;
`endif

    assign acc_nxt = acc + (b[0] ? a : 64'd0);
    assign prod    = neg ? -acc_nxt : acc_nxt;
    assign mul_res = op == ALU_MUL ? prod[31:0] : prod[63:32];
    assign trial   = {acc[31:0], b[31]} - {1'b0, a[31:0]};
    assign ge      = !trial[32];
    assign rem_nxt = ge ? trial[31:0] : {acc[30:0], b[31]};
    assign quo_nxt = {b[30:0], ge};
    assign div_res = (op inside {ALU_REM, ALU_REMU}) ? (neg ? -rem_nxt : rem_nxt) : (neg ? -quo_nxt : quo_nxt);

    assign busy = state != IDLE;
    assign done = state == DONE;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state: special cases and direct multiplies skip the iteration states
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (accept) state_nxt = (special || (is_mul_in && direct_mul)) ? DONE : is_mul_in ? MUL : DIV;
            MUL, DIV: state_nxt = flush ? IDLE : cnt == 6'd31 ? DONE : state;
            DONE:     state_nxt = IDLE;
        endcase
    end

    // operand latch at acceptance, one shift-add or restoring-divide step per iteration edge
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op     <= '0;
            rd_q   <= '0;
            neg    <= 1'b0;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            result <= '0;
            rd_out <= '0;
        end else if (accept) begin
            cnt  <= '0;
            op   <= alucode;
            neg  <= neg_in;
            rd_q <= rd_in;
            acc  <= '0;
            a    <= {32'd0, is_mul_in ? m1 : m2};
            b    <= is_mul_in ? m2 : m1;
            if (special || (is_mul_in && direct_mul)) begin
                result <= special ? special_res : fast_res;
                rd_out <= rd_in;
            end
        end else if ((state == MUL || state == DIV) && !flush) begin
            cnt <= cnt + 6'd1;
            acc <= state == MUL ? acc_nxt : {32'd0, rem_nxt};
            a   <= state == MUL ? a << 1 : a;
            b   <= state == MUL ? b >> 1 : quo_nxt;
            if (cnt == 6'd31) begin
                result <= state == MUL ? mul_res : div_res;
                rd_out <= rd_q;
            end
        end
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M execution unit, directly downstream of the instruction decoder, in parallel with the single-cycle ALU.
- Accepts the decoder's 6-bit alucode (ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, encodings per define.vh) plus the two operand values and the destination register number.
- Computes the result iteratively, one bit per cycle, and signals completion so the pipeline can stall on busy and write back on done.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- alucode  input  6  operation code from the decoder.
- src1  input  32  rs1 value (multiplicand / dividend).
- src2  input  32  rs2 value (multiplier / divisor).
- rd_in  input  5  destination register of the request.
- flush  input  1  kill the in-flight operation (branch mispredict / trap).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse: result and rd_out are valid.
- result  output  32  final value; held until the next accepted start.
- rd_out  output  5  destination latched at acceptance.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0. Reset overrides start and flush in the same cycle.
- States: IDLE, MUL, DIV, DONE.
- Acceptance: in IDLE, start=1 with an M-extension alucode latches the operands, the op and rd_in at edge k.
  - Any other alucode with start=1 is ignored: stays IDLE, no done.
  - start while busy is ignored.
- Operand preparation at acceptance, 32-bit magnitudes:
  - MUL/MULH: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - DIV/REM: both signed.
  - Result sign: MUL* = XOR of the signed-treated operand signs. DIV = s1^s2. REM = sign of dividend.
- MUL state: shift-add on a 64-bit accumulator. One multiplier bit per edge, edges k+1..k+32, then DONE.
  - The final 64-bit product is negated if the result sign is 1.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- DIV state: restoring division. One quotient bit per edge, edges k+1..k+32, then DONE.
  - Quotient and remainder are negated per their result signs.
- Special cases resolve at edge k, going directly to DONE (done visible in the cycle after k):
  - Divide by zero (src2=0): DIV/DIVU quotient = 32'hFFFFFFFF; REM/REMU = src1.
  - Signed overflow (DIV/REM with src1=32'h80000000, src2=32'hFFFFFFFF): quotient = 32'h80000000; remainder = 0.
- Latency: normal operations assert done in the cycle following edge k+32, i.e. 33 cycles after acceptance.
- DONE: done=1 and busy=1 for exactly one cycle. The next edge returns to IDLE with done=0. A start in DONE is ignored.
- Counter: 6-bit, cleared at acceptance, increments each iteration edge. The state exits MUL/DIV when counter reaches 31 at an edge. It never wraps in normal use.
- flush=1 at any edge in MUL, DIV or DONE: go to IDLE, done=0, result and rd_out unchanged. In IDLE, flush has no effect.
  - Simultaneous flush and start in IDLE: start is ignored.
- result and rd_out update only on entry to DONE.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: all MUL* ops use a combinational 64-bit multiplier.
  - Accepted at edge k, the unit goes directly to DONE; done is visible the cycle after k, a 1-cycle latency.
  - The MUL state is unused. Division is unchanged.
- Undefined: the iterative 33-cycle multiplier described above.

Test Plan:
- Reset: hold rst for 2 cycles with start=1 -> busy=0, done=0, result=0, rd_out=0; no acceptance.
- MUL: src1=7, src2=-3 (32'hFFFFFFFD), rd_in=5 -> done exactly 33 cycles later with result=32'hFFFFFFEB, rd_out=5. MULH on the same operands -> 32'hFFFFFFFF. MULHU on the same operands -> 32'h00000006.
- DIV: DIV src1=-20, src2=3 -> 32'hFFFFFFFA. REM on the same operands -> 32'hFFFFFFFE. DIVU src1=100, src2=7 -> 14. REMU on the same operands -> 2.
- Special cases: DIVU 5/0 -> 32'hFFFFFFFF. REM 5/0 -> 5. DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000. Each has done visible one cycle after acceptance.
- Flush and busy start: assert flush 10 cycles into a DIV -> IDLE next cycle, no done pulse, previous result retained. Assert start with a new op while busy -> ignored; the original result is unchanged.
- MULDIV_FAST_MUL_EN defined: MUL 32'h00010000 x 32'h00010000 -> done one cycle after acceptance, result=0. MULHU on the same operands -> 1.
